// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared definitions for the VGA raster timing generator.
//   - default 640x480@60 timing constants (pixels / lines)
//   - generator state enum (IDLE / RUN / DRAIN)
//   - calc_cw(): counter width needed to hold the larger of the two totals
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  function automatic int unsigned calc_cw(input int unsigned h_total,
                                          input int unsigned v_total);
    return (h_total > v_total) ? $clog2(h_total) : $clog2(v_total);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Ports:
//   iClk, iRst_n  clock / async active-low reset
//   iTick         advance the position by one (wraps TOTAL-1 -> 0)
//   iClear        force position 0 with all flags inactive (idle)
//   count         current position
//   sync          sync pulse, active level POL, for SYNC_START..+SYNC_LEN-1
//   visible       position < VISIBLE
//   last          position == TOTAL-1
// Flags are registered from the next position so they line up with count.
module vga_axis_counter #(
  parameter int unsigned CW         = 10,
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned VISIBLE    = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  parameter bit          POL        = 1'b0
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iTick,
  input  logic          iClear,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          visible,
  output logic          last
);

  localparam logic [CW-1:0] LAST_C = CW'(TOTAL - 1);
  localparam logic [CW-1:0] VIS_C  = CW'(VISIBLE);
  localparam logic [CW-1:0] SS_C   = CW'(SYNC_START);
  localparam logic [CW-1:0] SE_C   = CW'(SYNC_START + SYNC_LEN - 1);

  logic [CW-1:0] count_n;

  always_comb begin
    count_n = count;
    if (iClear) begin
      count_n = '0;
    end else if (iTick) begin
      count_n = (count == LAST_C) ? '0 : count + CW'(1);
    end
  end

  // Flags are re-decoded every clock; with neither tick nor clear the
  // position is unchanged, so they simply hold.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      count   <= '0;
      sync    <= ~POL;
      visible <= 1'b0;
      last    <= 1'b0;
    end else begin
      count   <= count_n;
      sync    <= (!iClear && count_n >= SS_C && count_n <= SE_C) ? POL : ~POL;
      visible <= !iClear && (count_n < VIS_C);
      last    <= !iClear && (count_n == LAST_C);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with run/stop.
// Ports:
//   iClk, iRst_n  clock / async active-low reset
//   iPixEn        pixel tick; nothing advances while low
//   iRun          raster request, sampled on ticks; dropping it lets the
//                 current frame finish (DRAIN) before returning to IDLE
//   oHCount/oVCount  current position
//   oHSync/oVSync    sync pulses (active level from *_SYNC_POL)
//   oActive       inside visible area
//   oLineEnd      last pixel of a line
//   oFrameStart   position (0,0) while running
//   oBusy         not IDLE
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned H_SYNC_POL = 0,
  parameter int unsigned V_SYNC_POL = 0,
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned CW        = calc_cw(H_TOTAL, V_TOTAL)
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iPixEn,
  input  logic          iRun,
  output logic [CW-1:0] oHCount,
  output logic [CW-1:0] oVCount,
  output logic          oHSync,
  output logic          oVSync,
  output logic          oActive,
  output logic          oLineEnd,
  output logic          oFrameStart,
  output logic          oBusy
);

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
    $error("vga_timing_gen: every timing parameter must be at least 1");
  end
  if (H_SYNC_POL > 1 || V_SYNC_POL > 1) begin : g_bad_pol
    $error("vga_timing_gen: sync polarity parameters must be 0 or 1");
  end

  state_t state, state_n;
  logic   tick, clear;
  logic   h_vis, v_vis, h_last, v_last;
  logic   frame_start;

  // In IDLE the counters are held cleared. Entering RUN issues neither
  // clear nor tick, so the flags get decoded from the (already zero) position.
  always_comb begin
    state_n = state;
    tick    = 1'b0;
    clear   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        clear = 1'b1;
        if (iPixEn && iRun) begin
          state_n = ST_RUN;
          clear   = 1'b0;
        end
      end
      ST_RUN: begin
        if (iPixEn) begin
          tick = 1'b1;
          if (!iRun) state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (iPixEn) begin
          if (iRun) begin
            state_n = ST_RUN;
            tick    = 1'b1;
          end else if (h_last && v_last) begin
            state_n = ST_IDLE;
            clear   = 1'b1;
          end else begin
            tick = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= ST_IDLE;
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      if (iPixEn) begin
        if (state_n == ST_IDLE)     frame_start <= 1'b0;
        else if (state == ST_IDLE)  frame_start <= 1'b1;
        else                        frame_start <= h_last && v_last;
      end
    end
  end

  vga_axis_counter #(
    .CW(CW), .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE),
    .SYNC_START(H_VISIBLE + H_FRONT), .SYNC_LEN(H_SYNC), .POL(H_SYNC_POL[0])
  ) u_h (
    .iClk(iClk), .iRst_n(iRst_n), .iTick(tick), .iClear(clear),
    .count(oHCount), .sync(oHSync), .visible(h_vis), .last(h_last)
  );

  vga_axis_counter #(
    .CW(CW), .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE),
    .SYNC_START(V_VISIBLE + V_FRONT), .SYNC_LEN(V_SYNC), .POL(V_SYNC_POL[0])
  ) u_v (
    .iClk(iClk), .iRst_n(iRst_n), .iTick(tick && h_last), .iClear(clear),
    .count(oVCount), .sync(oVSync), .visible(v_vis), .last(v_last)
  );

  assign oActive     = h_vis && v_vis;
  assign oLineEnd    = h_last;
  assign oFrameStart = frame_start;
  assign oBusy       = (state != ST_IDLE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, a mid-size
// raster with mixed polarities, and a tiny raster with positive syncs) share
// one stimulus stream. A linear-index raster model predicts every output of
// every instance each cycle; directed literal checks pin the model.
module tb_vga_timing_gen;

  localparam int N = 3;
  localparam int unsigned P_HV [N] = '{640, 20, 4};
  localparam int unsigned P_HF [N] = '{16,  3,  1};
  localparam int unsigned P_HS [N] = '{96,  5,  2};
  localparam int unsigned P_HB [N] = '{48,  4,  1};
  localparam int unsigned P_VV [N] = '{480, 10, 3};
  localparam int unsigned P_VF [N] = '{10,  2,  1};
  localparam int unsigned P_VS [N] = '{2,   2,  1};
  localparam int unsigned P_VB [N] = '{33,  3,  1};
  localparam int unsigned P_HP [N] = '{0,   1,  1};
  localparam int unsigned P_VP [N] = '{0,   0,  1};

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] v;
    logic        hs, vs, act, le, fs, busy;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] h0, v0;
  logic [4:0] h1, v1;
  logic [2:0] h2, v2;
  logic hs [N], vs [N], act [N], le [N], fs [N], busy [N];
  logic [31:0] dh [N], dv [N];
  assign dh[0] = 32'(h0);
  assign dv[0] = 32'(v0);
  assign dh[1] = 32'(h1);
  assign dv[1] = 32'(v1);
  assign dh[2] = 32'(h2);
  assign dv[2] = 32'(v2);

  vga_timing_gen u_dut0 (
    .iClk(clk), .iRst_n(rst_n), .iPixEn(pix_en), .iRun(run),
    .oHCount(h0), .oVCount(v0), .oHSync(hs[0]), .oVSync(vs[0]), .oActive(act[0]),
    .oLineEnd(le[0]), .oFrameStart(fs[0]), .oBusy(busy[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1), .V_SYNC_POL(0)
  ) u_dut1 (
    .iClk(clk), .iRst_n(rst_n), .iPixEn(pix_en), .iRun(run),
    .oHCount(h1), .oVCount(v1), .oHSync(hs[1]), .oVSync(vs[1]), .oActive(act[1]),
    .oLineEnd(le[1]), .oFrameStart(fs[1]), .oBusy(busy[1])
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1), .V_SYNC_POL(1)
  ) u_dut2 (
    .iClk(clk), .iRst_n(rst_n), .iPixEn(pix_en), .iRun(run),
    .oHCount(h2), .oVCount(v2), .oHSync(hs[2]), .oVSync(vs[2]), .oActive(act[2]),
    .oLineEnd(le[2]), .oFrameStart(fs[2]), .oBusy(busy[2])
  );

  int checks = 0;
  int failures = 0;

  // Model: state (0 idle, 1 run, 2 drain) and linear raster index p = v*HT+h.
  int unsigned mst [N] = '{default: 0};
  int unsigned mp  [N] = '{default: 0};

  function automatic int unsigned htot(int i);
    return P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i];
  endfunction
  function automatic int unsigned vtot(int i);
    return P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        mst[i] = 0;
        mp[i]  = 0;
      end else if (pix_en) begin
        if (mst[i] == 0) begin
          if (run) begin
            mst[i] = 1;
            mp[i]  = 0;
          end
        end else if (mst[i] == 2 && !run && mp[i] == htot(i) * vtot(i) - 1) begin
          mst[i] = 0;
          mp[i]  = 0;
        end else begin
          mst[i] = run ? 1 : 2;
          mp[i]  = (mp[i] + 1) % (htot(i) * vtot(i));
        end
      end
    end
  end

  function automatic out_t expect_out(int i);
    out_t e;
    int unsigned h, v, hss, vss;
    logic hp, vp;
    hp = (P_HP[i] != 0);
    vp = (P_VP[i] != 0);
    h = mp[i] % htot(i);
    v = mp[i] / htot(i);
    hss = P_HV[i] + P_HF[i];
    vss = P_VV[i] + P_VF[i];
    if (mst[i] == 0) begin
      e = '{h: 32'd0, v: 32'd0, hs: ~hp, vs: ~vp, act: 1'b0, le: 1'b0, fs: 1'b0, busy: 1'b0};
    end else begin
      e.h    = h;
      e.v    = v;
      e.hs   = (h >= hss && h < hss + P_HS[i]) ? hp : ~hp;
      e.vs   = (v >= vss && v < vss + P_VS[i]) ? vp : ~vp;
      e.act  = (h < P_HV[i]) && (v < P_VV[i]);
      e.le   = (h == htot(i) - 1);
      e.fs   = (h == 0) && (v == 0);
      e.busy = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      out_t e, a;
      e = expect_out(i);
      a = '{h: dh[i], v: dv[i], hs: hs[i], vs: vs[i], act: act[i], le: le[i], fs: fs[i], busy: busy[i]};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL model_cmp dut%0d t=%0t got h=%0d v=%0d hs,vs,act,le,fs,busy=%b%b%b%b%b%b expected h=%0d v=%0d hs,vs,act,le,fs,busy=%b%b%b%b%b%b",
                 i, $time, a.h, a.v, a.hs, a.vs, a.act, a.le, a.fs, a.busy,
                 e.h, e.v, e.hs, e.vs, e.act, e.le, e.fs, e.busy);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  initial begin
    int unsigned hs_low, sm_hs, sm_vs, sm_act, sm_fs, changes, k;
    logic [31:0] prev;

    // Reset state and idle after release with iRun=0.
    rst_n = 1'b0; run = 1'b0; pix_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_h0", dh[0], 0);
    chk("rst_v0", dv[0], 0);
    chk("rst_hs0", hs[0], 1);
    chk("rst_vs0", vs[0], 1);
    chk("rst_act0", act[0], 0);
    chk("rst_busy0", busy[0], 0);
    chk("rst_hs2", hs[2], 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy0", busy[0], 0);
    chk("idle_fs0", fs[0], 0);

    // Continuous run from (0,0): tick n shows raster index n-1.
    run = 1'b1;
    hs_low = 0; sm_hs = 0; sm_vs = 0; sm_act = 0; sm_fs = 0;
    for (int n = 1; n <= 1501; n++) begin
      @(negedge clk);
      if (n <= 800 && !hs[0]) hs_low++;
      if (n <= 48) begin
        sm_hs += 32'(hs[2]);
        sm_vs += 32'(vs[2]);
        sm_act += 32'(act[2]);
      end
      if (n <= 96) sm_fs += 32'(fs[2]);
      case (n)
        1: begin
          chk("start_h0", dh[0], 0);
          chk("start_fs0", fs[0], 1);
          chk("start_act0", act[0], 1);
        end
        656: chk("h655_hsync0", hs[0], 1);
        657: begin
          chk("h656_pos0", dh[0], 656);
          chk("h656_hsync0", hs[0], 0);
        end
        752: chk("h751_hsync0", hs[0], 0);
        753: chk("h752_hsync0", hs[0], 1);
        800: chk("h799_lineend0", le[0], 1);
        801: begin
          chk("wrap_h0", dh[0], 0);
          chk("wrap_v0", dv[0], 1);
          chk("wrap_fs0", fs[0], 0);
        end
        default: ;
      endcase
    end
    chk("hsync_low_ticks0", hs_low, 96);
    chk("small_hsync_ticks", sm_hs, 12);
    chk("small_vsync_ticks", sm_vs, 8);
    chk("small_active_ticks", sm_act, 12);
    chk("small_framestart_2frames", sm_fs, 2);

    // Asynchronous reset inside the horizontal sync pulse.
    chk("pre_rst_h0", dh[0], 700);
    chk("pre_rst_hsync0", hs[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hsync0", hs[0], 1);
    chk("async_rst_h0", dh[0], 0);
    chk("async_rst_busy0", busy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_h0", dh[0], 0);
    chk("restart_v0", dv[0], 0);
    chk("restart_fs0", fs[0], 1);
    chk("restart_busy0", busy[0], 1);

    // One tick every 4 clocks: exactly one position change per tick.
    changes = 0;
    prev = dh[2];
    for (int n = 0; n < 40; n++) begin
      pix_en = (n % 4 == 0);
      @(negedge clk);
      if (dh[2] != prev) changes++;
      prev = dh[2];
    end
    chk("quarter_rate_changes2", changes, 10);
    pix_en = 1'b1;

    // Drain on the tiny raster: drop iRun at index 10 -> IDLE after index 47.
    k = 0;
    while (!fs[2] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_framestart2", fs[2], 1);
    repeat (10) @(negedge clk);
    run = 1'b0;
    repeat (37) @(negedge clk);
    chk("drain_last_h2", dh[2], 7);
    chk("drain_last_v2", dv[2], 5);
    chk("drain_last_busy2", busy[2], 1);
    chk("drain_last_le2", le[2], 1);
    @(negedge clk);
    chk("drain_idle_busy2", busy[2], 0);
    chk("drain_idle_h2", dh[2], 0);

    // Reassert during DRAIN at (5,5): wraps into (0,0) without a gap.
    run = 1'b1;
    @(negedge clk);
    chk("rerun_fs2", fs[2], 1);
    run = 1'b0;
    repeat (45) @(negedge clk);
    chk("redrain_h2", dh[2], 5);
    chk("redrain_v2", dv[2], 5);
    chk("redrain_busy2", busy[2], 1);
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("nogap_h2", dh[2], 0);
    chk("nogap_v2", dv[2], 0);
    chk("nogap_fs2", fs[2], 1);
    chk("nogap_busy2", busy[2], 1);

    // Randomised phases of tick density, run toggling and async resets.
    for (int ph = 0; ph < 40; ph++) begin
      int unsigned mode, len;
      mode = $urandom_range(0, 2);
      len  = $urandom_range(50, 1200);
      run  = ($urandom_range(0, 99) < 60);
      for (int c = 0; c < int'(len); c++) begin
        @(negedge clk);
        case (mode)
          0: pix_en = 1'b1;
          1: pix_en = (c % 4 == 0);
          default: pix_en = 1'($urandom_range(0, 1));
        endcase
        if ($urandom_range(0, 199) == 0) run = ~run;
      end
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rnd_async_rst_busy1", busy[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
